// File: rtl/m2n_dec.sv
// Registered binary-to-one-hot decoder with programmable hold time, a valid/ready
// input handshake, out-of-range flagging and wrapping accept/reject counters.
module m2n_dec #(
    parameter int N    = 42,
    parameter int M    = 6,
    parameter int HOLD = 4
) (
    input  logic         Clk_i,
    input  logic         Rst_n_i,
    input  logic         Dec_Clr_i,
    input  logic         Dec_Vld_i,
    input  logic [M-1:0] Dec_Dat_i,
    output logic         Dec_Rdy_o,
    output logic [N-1:0] Dec_Dat_o,
    output logic         Dec_Vld_o,
    output logic         Dec_Err_o,
    output logic [15:0]  Dec_Cnt_o,
    output logic [15:0]  Dec_Ecnt_o
);

    // state   | meaning
    // ST_IDLE | no word held, ready for a code
    // ST_HOLD | one-hot word asserted, hcnt counts down the remaining cycles
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [M:0] N_L      = (M+1)'(N);
    localparam logic [7:0] HOLD_TOP = 8'(HOLD - 1);

    state_t       state, state_nxt;
    logic [7:0]   hcnt, hcnt_nxt;
    logic [N-1:0] dat_nxt, onehot;
    logic         vld_nxt, err_nxt;
    logic [15:0]  cnt_nxt, ecnt_nxt;
    logic         accept, in_range;

    assign Dec_Rdy_o = Rst_n_i & ~Dec_Clr_i & ((state == ST_IDLE) | (hcnt == 8'd0));
    assign accept    = Dec_Vld_i & Dec_Rdy_o;
    assign in_range  = ({1'b0, Dec_Dat_i} < N_L);

    // Codes >= N never match any bit, so the decode is all-zero for them.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (Dec_Dat_i == M'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        dat_nxt   = Dec_Dat_o;
        vld_nxt   = Dec_Vld_o;
        err_nxt   = 1'b0;
        cnt_nxt   = Dec_Cnt_o;
        ecnt_nxt  = Dec_Ecnt_o;
        if (Dec_Clr_i) begin
            state_nxt = ST_IDLE;
            hcnt_nxt  = 8'd0;
            dat_nxt   = '0;
            vld_nxt   = 1'b0;
        end else if (accept) begin
            if (in_range) begin
                state_nxt = ST_HOLD;
                hcnt_nxt  = HOLD_TOP;
                dat_nxt   = onehot;
                vld_nxt   = 1'b1;
                cnt_nxt   = Dec_Cnt_o + 16'd1;
            end else begin
                state_nxt = ST_IDLE;
                hcnt_nxt  = 8'd0;
                dat_nxt   = '0;
                vld_nxt   = 1'b0;
                err_nxt   = 1'b1;
                ecnt_nxt  = Dec_Ecnt_o + 16'd1;
            end
        end else if (state == ST_HOLD) begin
            if (hcnt != 8'd0) begin
                hcnt_nxt = hcnt - 8'd1;
            end else begin
                state_nxt = ST_IDLE;
                dat_nxt   = '0;
                vld_nxt   = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            state      <= ST_IDLE;
            hcnt       <= 8'd0;
            Dec_Dat_o  <= '0;
            Dec_Vld_o  <= 1'b0;
            Dec_Err_o  <= 1'b0;
            Dec_Cnt_o  <= 16'd0;
            Dec_Ecnt_o <= 16'd0;
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            Dec_Dat_o  <= dat_nxt;
            Dec_Vld_o  <= vld_nxt;
            Dec_Err_o  <= err_nxt;
            Dec_Cnt_o  <= cnt_nxt;
            Dec_Ecnt_o <= ecnt_nxt;
        end
    end

endmodule

// File: tb/tb_m2n_dec.sv
// Bench for m2n_dec: directed vector table, back-to-back sweep, random run against a
// timestamp-based reference model (HOLD=4 instance), and a HOLD=1 wrap stream.
module tb_m2n_dec;

    localparam int N  = 42;
    localparam int M  = 6;
    localparam int H4 = 4;

    logic         clk;
    logic         rst_a, clr_a, vld_a;
    logic [M-1:0] code_a;
    logic         rdy_a, vo_a, err_a;
    logic [N-1:0] dat_a;
    logic [15:0]  cnt_a, ecnt_a;

    logic         rst_b, clr_b, vld_b;
    logic [M-1:0] code_b;
    logic         rdy_b, vo_b, err_b;
    logic [N-1:0] dat_b;
    logic [15:0]  cnt_b, ecnt_b;

    int total = 0;
    int bad   = 0;

    m2n_dec #(.N(N), .M(M), .HOLD(H4)) u_h4 (
        .Clk_i(clk), .Rst_n_i(rst_a), .Dec_Clr_i(clr_a), .Dec_Vld_i(vld_a),
        .Dec_Dat_i(code_a), .Dec_Rdy_o(rdy_a), .Dec_Dat_o(dat_a), .Dec_Vld_o(vo_a),
        .Dec_Err_o(err_a), .Dec_Cnt_o(cnt_a), .Dec_Ecnt_o(ecnt_a)
    );

    m2n_dec #(.N(N), .M(M), .HOLD(1)) u_h1 (
        .Clk_i(clk), .Rst_n_i(rst_b), .Dec_Clr_i(clr_b), .Dec_Vld_i(vld_b),
        .Dec_Dat_i(code_b), .Dec_Rdy_o(rdy_b), .Dec_Dat_o(dat_b), .Dec_Vld_o(vo_b),
        .Dec_Err_o(err_b), .Dec_Cnt_o(cnt_b), .Dec_Ecnt_o(ecnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] hot(input int idx);
        logic [N-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    // Reference model: remembers the edge index of the last in-range accept and
    // derives visibility and readiness from elapsed cycles.
    int          t_now   = 0;
    int          t_acc   = 0;
    bit          have    = 0;
    int          code_m  = 0;
    bit          err_m   = 0;
    logic [15:0] cnt_m   = 0;
    logic [15:0] ecnt_m  = 0;

    function automatic bit m_vis();
        return have && (t_now - t_acc) < H4;
    endfunction

    function automatic bit m_rdy(input bit rst, input bit clr);
        return rst && !clr && (!m_vis() || (t_now - t_acc) >= H4 - 1);
    endfunction

    // One cycle on the HOLD=4 instance with full model checking.
    task automatic step(input bit rst, input bit clr, input bit vld, input int code,
                        output bit accepted);
        bit r;
        int idx;
        rst_a = rst; clr_a = clr; vld_a = vld; code_a = M'(code);
        #1;
        r = m_rdy(rst, clr);
        check("rdy", 64'(rdy_a), 64'(r));
        accepted = vld && r;
        @(posedge clk);
        t_now++;
        if (!rst) begin
            have = 0; err_m = 0; cnt_m = 0; ecnt_m = 0;
        end else if (clr) begin
            have = 0; err_m = 0;
        end else if (accepted) begin
            if (code < N) begin
                have = 1; t_acc = t_now; code_m = code; cnt_m++; err_m = 0;
            end else begin
                have = 0; err_m = 1; ecnt_m++;
            end
        end else begin
            err_m = 0;
        end
        @(negedge clk);
        check("vld_o", 64'(vo_a), 64'(m_vis()));
        check("dat_o", 64'(dat_a), m_vis() ? 64'(hot(code_m)) : 64'(0));
        check("err_o", 64'(err_a), 64'(err_m));
        check("cnt_o", 64'(cnt_a), 64'(cnt_m));
        check("ecnt_o", 64'(ecnt_a), 64'(ecnt_m));
        check("multihot", 64'($countones(dat_a) > 1), 64'(0));
        if (vo_a) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (dat_a[i]) idx = i;
            check("encode_back", 64'(idx), 64'(code_m));
        end
    endtask

    typedef struct {
        bit rst; bit clr; bit vld; int code;
        bit e_rdy; bit e_vo; int e_idx; bit e_err; int e_cnt; int e_ecnt;
    } vec_t;

    vec_t vt[$];

    initial begin
        bit acc;
        int tries, drops;
        bit seen;

        rst_a = 0; clr_a = 0; vld_a = 0; code_a = '0;
        rst_b = 0; clr_b = 0; vld_b = 0; code_b = '0;

        //        rst clr vld code rdy vo idx err cnt ecnt
        vt.push_back('{0, 0, 0,  0, 0, 0,  0, 0, 0, 0});
        vt.push_back('{1, 0, 1,  5, 1, 1,  5, 0, 1, 0});
        vt.push_back('{1, 0, 1,  7, 0, 1,  5, 0, 1, 0});
        vt.push_back('{1, 0, 0,  0, 0, 1,  5, 0, 1, 0});
        vt.push_back('{1, 0, 0,  0, 0, 1,  5, 0, 1, 0});
        vt.push_back('{1, 0, 0,  0, 1, 0,  0, 0, 1, 0});
        vt.push_back('{1, 0, 1, 42, 1, 0,  0, 1, 1, 1});
        vt.push_back('{1, 0, 1, 63, 1, 0,  0, 1, 1, 2});
        vt.push_back('{1, 0, 0,  0, 1, 0,  0, 0, 1, 2});
        vt.push_back('{1, 0, 1, 10, 1, 1, 10, 0, 2, 2});
        vt.push_back('{1, 0, 0,  0, 0, 1, 10, 0, 2, 2});
        vt.push_back('{1, 1, 1,  3, 0, 0,  0, 0, 2, 2});
        vt.push_back('{1, 0, 0,  0, 1, 0,  0, 0, 2, 2});
        vt.push_back('{1, 0, 1, 41, 1, 1, 41, 0, 3, 2});
        vt.push_back('{1, 0, 1, 42, 0, 1, 41, 0, 3, 2});
        vt.push_back('{1, 0, 0,  0, 0, 1, 41, 0, 3, 2});
        vt.push_back('{1, 0, 1,  9, 0, 1, 41, 0, 3, 2});
        vt.push_back('{1, 0, 1, 42, 1, 0,  0, 1, 3, 3});
        vt.push_back('{1, 0, 0,  0, 1, 0,  0, 0, 3, 3});
        vt.push_back('{1, 0, 1,  2, 1, 1,  2, 0, 4, 3});
        vt.push_back('{0, 0, 1,  6, 0, 0,  0, 0, 0, 0});
        vt.push_back('{1, 0, 0,  0, 1, 0,  0, 0, 0, 0});

        @(negedge clk);
        foreach (vt[i]) begin
            rst_a = vt[i].rst; clr_a = vt[i].clr; vld_a = vt[i].vld; code_a = M'(vt[i].code);
            #1;
            check($sformatf("v%0d_rdy", i), 64'(rdy_a), 64'(vt[i].e_rdy));
            @(negedge clk);
            check($sformatf("v%0d_vo", i), 64'(vo_a), 64'(vt[i].e_vo));
            check($sformatf("v%0d_dat", i), 64'(dat_a),
                  vt[i].e_vo ? 64'(hot(vt[i].e_idx)) : 64'(0));
            check($sformatf("v%0d_err", i), 64'(err_a), 64'(vt[i].e_err));
            check($sformatf("v%0d_cnt", i), 64'(cnt_a), 64'(vt[i].e_cnt));
            check($sformatf("v%0d_ecnt", i), 64'(ecnt_a), 64'(vt[i].e_ecnt));
        end

        // Back-to-back sweep of every legal code; the word must never drop.
        step(0, 0, 0, 0, acc);
        drops = 0;
        seen  = 0;
        for (int c = 0; c < N; c++) begin
            tries = 0;
            do begin
                step(1, 0, 1, c, acc);
                if (seen && !vo_a) drops++;
                if (vo_a) seen = 1;
                tries++;
            end while (!acc && tries < 10);
            check($sformatf("sweep_accept_%0d", c), 64'(acc), 64'(1));
        end
        check("sweep_no_drop", 64'(drops), 64'(0));
        check("sweep_cnt", 64'(cnt_a), 64'(N));

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7), int'($urandom_range(0, 63)), acc);
        end

        // HOLD=1 continuous stream across the counter wrap.
        step(1, 0, 0, 0, acc);
        #1;
        check("h1_rdy_in_reset", 64'(rdy_b), 64'(0));
        @(negedge clk);
        rst_b = 1;
        #1;
        check("h1_rdy_after_release", 64'(rdy_b), 64'(1));
        @(negedge clk);
        drops = 0;
        for (int i = 0; i < 70000; i++) begin
            vld_b = 1; code_b = M'(i % N);
            #1;
            if (rdy_b !== 1'b1) drops++;
            @(negedge clk);
            if (vo_b !== 1'b1 || dat_b !== hot(i % N) || err_b !== 1'b0) drops++;
        end
        check("h1_stream_errors", 64'(drops), 64'(0));
        check("h1_cnt_wrap", 64'(cnt_b), 64'(70000 - 65536));
        check("h1_ecnt", 64'(ecnt_b), 64'(0));
        vld_b = 0;
        @(negedge clk);
        check("h1_idle_vo", 64'(vo_b), 64'(0));
        check("h1_idle_dat", 64'(dat_b), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m2n_dec.md
# m2n_dec

Registered binary-to-one-hot decoder: converts an M-bit code into an N-bit one-hot word and holds it for a programmable number of cycles. It is the inverse of the N-to-M one-hot encoder and sits at the other end of the same select path: it regenerates one-hot strobes from a compact code delivered by an upstream requester over a valid/ready handshake. It also flags codes outside the range and counts accepted and rejected codes.

## Interface
- N, 42, one-hot output width; legal codes are 0..N-1.
- M, 6, code width; must satisfy 2**M >= N.
- HOLD, 4, cycles each one-hot word stays asserted; legal range 1..255.
- Clk_i  in  1  clock; all state changes on the rising edge.
- Rst_n_i  in  1  reset, synchronous, active-low.
- Dec_Clr_i  in  1  synchronous abort; drops any held word and returns to IDLE.
- Dec_Vld_i  in  1  Dec_Dat_i is valid.
- Dec_Dat_i  in  M  binary code.
- Dec_Rdy_o  out  1  block accepts a code this cycle.
- Dec_Dat_o  out  N  registered one-hot word; all zero when idle.
- Dec_Vld_o  out  1  Dec_Dat_o carries a decoded word.
- Dec_Err_o  out  1  one-cycle pulse: an accepted code was >= N.
- Dec_Cnt_o  out  16  count of accepted in-range codes; wraps at 65535 to 0.
- Dec_Ecnt_o  out  16  count of accepted out-of-range codes; wraps at 65535 to 0.

## Operation
- State machine with two states, IDLE and HOLD. There is an internal 8-bit down-counter, hcnt.
- Accept = Dec_Vld_i & Dec_Rdy_o.
- Dec_Rdy_o is combinational:
  - 1 in IDLE.
  - 1 in HOLD when hcnt == 0, so back-to-back codes are accepted with no gap.
  - 0 otherwise.
  - 0 while Rst_n_i = 0 or Dec_Clr_i = 1.
- Accept with code < N:
  - Dec_Dat_o <= 1 << code; Dec_Vld_o <= 1; hcnt <= HOLD-1.
  - State <= HOLD; Dec_Cnt_o increments.
- Accept with code >= N:
  - Dec_Dat_o <= 0; Dec_Vld_o <= 0; Dec_Err_o <= 1 for one cycle.
  - State <= IDLE; Dec_Ecnt_o increments.
- HOLD with no accept:
  - If hcnt != 0: hcnt decrements and the outputs hold.
  - If hcnt == 0: Dec_Dat_o <= 0; Dec_Vld_o <= 0; state <= IDLE.
- Dec_Err_o deasserts on the cycle after it is set unless another out-of-range code is accepted.
- Dec_Clr_i = 1 in any state:
  - Next edge: Dec_Dat_o = 0, Dec_Vld_o = 0, Dec_Err_o = 0, state = IDLE, hcnt = 0.
  - The counters keep their values.
  - No accept can occur that cycle.
- Priority: Rst_n_i, then Dec_Clr_i, then accept, then hold/expire.
- Dec_Dat_o is at all times either all-zero or exactly one bit set. It is never multi-hot.
- Dec_Dat_i is ignored when there is no accept. It may change freely while Dec_Rdy_o = 0.

## Timing
- Reset (Rst_n_i low at an edge) sets: state IDLE, hcnt 0, Dec_Dat_o 0, Dec_Vld_o 0, Dec_Err_o 0, Dec_Cnt_o 0, Dec_Ecnt_o 0.
  - Dec_Rdy_o = 0 during reset and 1 in the first cycle after release.
- Latency: a code accepted at edge k appears on Dec_Dat_o/Dec_Vld_o after edge k. It stays asserted for exactly HOLD cycles, edges k..k+HOLD-1, then clears after edge k+HOLD unless a new code is accepted at edge k+HOLD.
- HOLD = 1: Dec_Rdy_o stays 1 continuously. Each accept gives a one-cycle strobe, and a continuous Dec_Vld_i stream gives one new word per cycle.
- Back-to-back accept in the last HOLD cycle: the new word replaces the old at the next edge with no zero cycle between them. Dec_Vld_o stays 1.
- Out-of-range code accepted during the last HOLD cycle: Dec_Dat_o/Dec_Vld_o clear at the next edge, concurrent with the Dec_Err_o pulse.
- Reset mid-HOLD: the outputs clear at that edge, with no partial hold afterwards.
- Counter wrap: 65535 + 1 = 0, with no saturation and no flag.

## Test plan
- Reset, then accept code 5 with HOLD = 4 -> Dec_Dat_o = 1<<5 and Dec_Vld_o = 1 for exactly 4 cycles, Dec_Rdy_o low for the first 3 of them, then zero; Dec_Cnt_o = 1.
- Sweep codes 0..41 back-to-back, each offered as soon as Dec_Rdy_o = 1 -> each output has exactly one bit set, bit index = code; Dec_Vld_o never drops; Dec_Cnt_o = 42.
- Codes 42 and 63 -> Dec_Dat_o stays 0, Dec_Err_o pulses one cycle per code, Dec_Ecnt_o = 2, Dec_Cnt_o unchanged.
- Accept code 10, assert Dec_Clr_i in the 2nd HOLD cycle -> outputs zero at the next edge, Dec_Rdy_o = 1 the following cycle, counters retained; likewise Rst_n_i low mid-HOLD -> all outputs and counters 0.
- HOLD = 1 with Dec_Vld_i held high for 70000 in-range codes -> one-cycle strobes every cycle; Dec_Cnt_o wraps to 70000-65536 = 4464.
- Random codes 0..63 with random Dec_Vld_i and Dec_Clr_i -> a scoreboard confirms Dec_Dat_o is never multi-hot and that encoding Dec_Dat_o back to binary with the N-to-M encoder returns the accepted code.
